// File: rtl/pong_pkg.sv
// Shared definitions for the pong ball and paddle blocks: display size,
// motion direction codes and the paddle FSM state encoding.
package pong_pkg;

    localparam int D_WIDTH  = 640;
    localparam int D_HEIGHT = 480;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_STILL = 2'd2;

    typedef enum logic [1:0] {
        ST_STILL = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } paddle_state_t;

    // Direction code reported for a move from x_cur to x_nxt.
    function automatic logic [1:0] move_dir(input logic [11:0] x_cur, input logic [11:0] x_nxt);
        if (x_nxt > x_cur)
            return DIR_RIGHT;
        else if (x_nxt < x_cur)
            return DIR_LEFT;
        else
            return DIR_STILL;
    endfunction

endpackage

// File: rtl/paddle_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stability counter
// that accepts a new level after it has held for DB_CYCLES clocks.
module btn_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(DB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_synced;

    assign w_synced = r_sync[1];
    assign o_level  = r_level;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (w_synced == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == TC) begin
            r_level <= w_synced;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: debounced buttons drive a STILL/LEFT/RIGHT FSM
// that moves and clamps the paddle on each animation strobe.
// Optional step boost after sustained motion: define PADDLE_ACCEL_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_STILL | no button or both buttons accepted; no motion
//   ST_LEFT  | only left accepted; step toward x = 0
//   ST_RIGHT | only right accepted; step toward x = XMAX
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int P_WIDTH    = 100,
    parameter int P_HEIGHT   = 10,
    parameter int IX         = 270,
    parameter int Y_TOP      = 440,
    parameter int SPEED      = 4,
    parameter int D_WIDTH    = pong_pkg::D_WIDTH,
    parameter int DB_CYCLES  = 250000,
    parameter int ACCEL_HOLD = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_btn_left,
    input  logic        i_btn_right,
    output logic [11:0] o_x,
    output logic [1:0]  o_dir,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2
);

    localparam int          XMAX   = D_WIDTH - P_WIDTH;
    localparam logic [12:0] XMAX13 = 13'(XMAX);

    logic          w_left;
    logic          w_right;
    logic          w_move_en;
    paddle_state_t r_state;
    paddle_state_t w_state_next;
    logic [11:0]   r_x;
    logic [1:0]    r_dir;
    logic [12:0]   w_step;
    logic [12:0]   w_sum;
    logic [11:0]   w_diff;
    logic [11:0]   w_x_next;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_left),
        .o_level (w_left)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_right),
        .o_level (w_right)
    );

    assign w_move_en = i_ani_stb && i_animate;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_STILL;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_move_en) begin
            case ({w_left, w_right})
                2'b10:   w_state_next = ST_LEFT;
                2'b01:   w_state_next = ST_RIGHT;
                default: w_state_next = ST_STILL;
            endcase
        end
    end

`ifdef PADDLE_ACCEL_EN
    localparam int ACW = $clog2(ACCEL_HOLD + 1);
    localparam logic [ACW-1:0] HOLD = ACW'(ACCEL_HOLD);

    logic [ACW-1:0] r_accel_cnt;
    logic           w_boost;

    // Boost only continues an unbroken run; a reversal strobe uses the base step.
    assign w_boost = (r_accel_cnt == HOLD) && (w_state_next == r_state) &&
                     (w_state_next != ST_STILL);
    assign w_step  = w_boost ? 13'(2 * SPEED) : 13'(SPEED);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_accel_cnt <= '0;
        end else if (w_move_en) begin
            if (w_state_next == ST_STILL || w_x_next == r_x)
                r_accel_cnt <= '0;
            else if (w_state_next != r_state)
                r_accel_cnt <= ACW'(1);
            else if (r_accel_cnt != HOLD)
                r_accel_cnt <= r_accel_cnt + 1'b1;
        end
    end
`else
    assign w_step = 13'(SPEED);
`endif

    assign w_sum  = {1'b0, r_x} + w_step;
    assign w_diff = r_x - w_step[11:0];

    always_comb begin
        w_x_next = r_x;
        case (w_state_next)
            ST_RIGHT: w_x_next = (w_sum > XMAX13) ? XMAX13[11:0] : w_sum[11:0];
            ST_LEFT:  w_x_next = ({1'b0, r_x} < w_step) ? 12'd0 : w_diff;
            default:  w_x_next = r_x;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x   <= 12'(IX);
            r_dir <= DIR_STILL;
        end else if (w_move_en) begin
            r_x   <= w_x_next;
            r_dir <= move_dir(r_x, w_x_next);
        end
    end

    assign o_x   = r_x;
    assign o_dir = r_dir;
    assign o_x1  = r_x;
    assign o_x2  = r_x + 12'(P_WIDTH);
    assign o_y1  = 12'(Y_TOP);
    assign o_y2  = 12'(Y_TOP + P_HEIGHT);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with a short debounce window (DB_CYCLES=4).
module tb_paddle_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_ani_stb = 1'b0;
    logic        i_animate = 1'b1;
    logic        i_btn_left = 1'b0;
    logic        i_btn_right = 1'b0;
    logic [11:0] o_x;
    logic [1:0]  o_dir;
    logic [11:0] o_x1;
    logic [11:0] o_x2;
    logic [11:0] o_y1;
    logic [11:0] o_y2;

    int checks = 0;
    int errors = 0;

    paddle_ctrl #(.DB_CYCLES(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ani_stb   (i_ani_stb),
        .i_animate   (i_animate),
        .i_btn_left  (i_btn_left),
        .i_btn_right (i_btn_right),
        .o_x         (o_x),
        .o_dir       (o_dir),
        .o_x1        (o_x1),
        .o_x2        (o_x2),
        .o_y1        (o_y1),
        .o_y2        (o_y2)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic strobe(input int n);
        for (int k = 0; k < n; k++) begin
            i_ani_stb = 1'b1;
            tick(1);
            i_ani_stb = 1'b0;
        end
    endtask

    task automatic buttons(input logic l, input logic r);
        i_btn_left  = l;
        i_btn_right = r;
        tick(8);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        tick(1);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Asynchronous reset taken mid-cycle, checked before any clock edge.
        #3 i_rst = 1'b1;
        #1;
        check("rst_x",   16'(o_x),   16'd270);
        check("rst_dir", 16'(o_dir), 16'd2);
        check("rst_x2",  16'(o_x2),  16'd370);
        check("rst_y1",  16'(o_y1),  16'd440);
        check("rst_y2",  16'(o_y2),  16'd450);
        tick(1);
        i_rst = 1'b0;
        tick(2);

        buttons(1'b0, 1'b1);
        strobe(1);
        check("right1_x",   16'(o_x),   16'd274);
        check("right1_dir", 16'(o_dir), 16'd0);
        strobe(9);
        check("right10_x",   16'(o_x),   16'd310);
        check("right10_dir", 16'(o_dir), 16'd0);
        check("right10_x2",  16'(o_x2),  16'd410);
        tick(5);
        check("hold_x",   16'(o_x),   16'd310);
        check("hold_dir", 16'(o_dir), 16'd0);
        buttons(1'b0, 1'b0);
        strobe(1);
        check("release_x",   16'(o_x),   16'd310);
        check("release_dir", 16'(o_dir), 16'd2);

        buttons(1'b0, 1'b1);
        strobe(1);
        check("premid_x", 16'(o_x), 16'd314);
        #4 i_rst = 1'b1;
        #1;
        check("midrst_x",   16'(o_x),   16'd270);
        check("midrst_dir", 16'(o_dir), 16'd2);
        i_btn_right = 1'b0;
        tick(1);
        i_rst = 1'b0;
        tick(8);

        buttons(1'b1, 1'b0);
        strobe(67);
        check("left67_x",   16'(o_x),   16'd2);
        check("left67_dir", 16'(o_dir), 16'd1);
        strobe(1);
        check("lwall_x",   16'(o_x),   16'd0);
        check("lwall_dir", 16'(o_dir), 16'd1);
        strobe(1);
        check("lpin_x",   16'(o_x),   16'd0);
        check("lpin_dir", 16'(o_dir), 16'd2);
        buttons(1'b0, 1'b0);

        do_reset();
        buttons(1'b0, 1'b1);
        strobe(67);
        check("right67_x", 16'(o_x), 16'd538);
        strobe(1);
        check("rwall_x",   16'(o_x),   16'd540);
        check("rwall_dir", 16'(o_dir), 16'd0);
        strobe(1);
        check("rpin_x",   16'(o_x),   16'd540);
        check("rpin_dir", 16'(o_dir), 16'd2);
        check("rpin_x2",  16'(o_x2),  16'd640);
        buttons(1'b0, 1'b0);

        do_reset();
        i_btn_right = 1'b1;
        tick(3);
        i_btn_right = 1'b0;
        tick(8);
        strobe(1);
        check("glitch_x",   16'(o_x),   16'd270);
        check("glitch_dir", 16'(o_dir), 16'd2);
        i_btn_right = 1'b1;
        tick(6);
        strobe(1);
        check("db6_x",   16'(o_x),   16'd274);
        check("db6_dir", 16'(o_dir), 16'd0);

        buttons(1'b1, 1'b1);
        strobe(1);
        check("both_x",   16'(o_x),   16'd274);
        check("both_dir", 16'(o_dir), 16'd2);
        buttons(1'b0, 1'b1);
        i_animate = 1'b0;
        strobe(3);
        check("noanim_x",   16'(o_x),   16'd274);
        check("noanim_dir", 16'(o_dir), 16'd2);
        i_animate = 1'b1;
        strobe(1);
        check("anim_x",   16'(o_x),   16'd278);
        check("anim_dir", 16'(o_dir), 16'd0);
        buttons(1'b0, 1'b0);

`ifdef PADDLE_ACCEL_EN
        do_reset();
        buttons(1'b1, 1'b0);
        strobe(70);
        check("acc_zero_x", 16'(o_x), 16'd0);
        buttons(1'b0, 1'b1);
        strobe(16);
        check("acc16_x", 16'(o_x), 16'd64);
        strobe(1);
        check("acc17_x", 16'(o_x), 16'd72);
        strobe(1);
        check("acc18_x", 16'(o_x), 16'd80);
        buttons(1'b1, 1'b0);
        strobe(1);
        check("acc_rev_x",   16'(o_x),   16'd76);
        check("acc_rev_dir", 16'(o_dir), 16'd1);
        buttons(1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
